// File: rtl/wb_arbiter_pkg.sv
// Shared configuration and types for the writeback arbiter and its result FIFO.
package wb_arbiter_pkg;

   localparam int          XLEN           = 32;
   localparam int          XREG_ADDRWIDTH = 5;
   localparam logic        WRITE_ENABLE   = 1'b1;
   localparam logic        RST_ENABLE     = 1'b1;
   localparam logic [31:0] ZERO_32BIT     = 32'h0000_0000;

   // Which source drives the register-file write port in the next cycle.
   typedef enum logic [1:0] {
      SEL_NONE   = 2'd0,
      SEL_ALU    = 2'd1,
      SEL_FIFO   = 2'd2,
      SEL_BYPASS = 2'd3
   } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous result FIFO. Entries are also exposed in age order
// (entry 0 = head = oldest) so the scoreboard and forwarding can see them.
module wb_fifo #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [AW-1:0]              push_rd,
   input  logic [DW-1:0]              push_data,
   input  logic                       pop,
   output logic [$clog2(DEPTH):0]     count,
   output logic [DEPTH-1:0]           ent_valid,
   output logic [DEPTH*AW-1:0]        ent_rd,
   output logic [DEPTH*DW-1:0]        ent_data
);
   import wb_arbiter_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] rd_q   [DEPTH];
   logic [AW-1:0] rd_d   [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [DW-1:0] data_d [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] idx_s;

   // Next-state: write at the tail, advance pointers, track occupancy.
   always_comb begin
      rd_d    = rd_q;
      data_d  = data_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         rd_d[wptr_q]   = push_rd;
         data_d[wptr_q] = push_data;
         wptr_d         = wptr_q + 1'b1;
      end else begin
         wptr_d = wptr_q;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end else begin
         rptr_d = rptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers; reset discards every buffered entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         for (int k = 0; k < DEPTH; k++) begin
            rd_q[k]   <= {AW{1'b0}};
            data_q[k] <= {DW{1'b0}};
         end
         wptr_q  <= {PW{1'b0}};
         rptr_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
      end else begin
         rd_q    <= rd_d;
         data_q  <= data_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Present the stored entries oldest-first, flagging which ones are live.
   always_comb begin
      idx_s     = {PW{1'b0}};
      ent_valid = {DEPTH{1'b0}};
      ent_rd    = {(DEPTH*AW){1'b0}};
      ent_data  = {(DEPTH*DW){1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         idx_s                  = rptr_q + PW'(k);
         ent_valid[k]           = (CW'(k) < count_q);
         ent_rd[k*AW +: AW]     = rd_q[idx_s];
         ent_data[k*DW +: DW]   = data_q[idx_s];
      end
   end

   assign count = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU pipe and the buffered LSU stream into the
// register file's single write port, ALU first, with a starvation guard that
// stalls the ALU so an aging LSU result can drain. Also publishes the set of
// in-flight writes as a pending mask and a forwarding lookup for decode.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN         = wb_arbiter_pkg::XLEN,
   parameter int REG_AW       = wb_arbiter_pkg::XREG_ADDRWIDTH,
   parameter int LSU_DEPTH    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_alu_valid,
   input  logic [REG_AW-1:0] i_alu_rd,
   input  logic [XLEN-1:0]   i_alu_data,
   input  logic              i_lsu_valid,
   output logic              o_lsu_ready,
   input  logic [REG_AW-1:0] i_lsu_rd,
   input  logic [XLEN-1:0]   i_lsu_data,
   output logic              o_alu_stall,
   output logic              o_write_flag,
   output logic [REG_AW-1:0] o_write_addr,
   output logic [XLEN-1:0]   o_write_data,
   output logic [31:0]       o_pend_mask,
   input  logic [REG_AW-1:0] i_fwd_addr,
   output logic              o_fwd_hit,
   output logic [XLEN-1:0]   o_fwd_data
);

   localparam int CW  = $clog2(LSU_DEPTH) + 1;
   localparam int AGW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(LSU_DEPTH);
   localparam logic [AGW-1:0] AGE_MAX  = AGW'(STARVE_LIMIT);

   logic                        alu_eff_s;
   logic                        lsu_hs_s;
   logic                        lsu_keep_s;
   logic                        fifo_empty_s;
   logic                        push_s;
   logic                        pop_s;
   wb_sel_e                     sel_s;
   logic [CW-1:0]               count_s;
   logic [CW-1:0]               count_next_s;
   logic [LSU_DEPTH-1:0]        ent_valid_s;
   logic [LSU_DEPTH*REG_AW-1:0] ent_rd_s;
   logic [LSU_DEPTH*XLEN-1:0]   ent_data_s;

   logic [AGW-1:0]    age_q, age_d;
   logic              alu_stall_q, alu_stall_d;
   logic              write_flag_q, write_flag_d;
   logic [REG_AW-1:0] write_addr_q, write_addr_d;
   logic [XLEN-1:0]   write_data_q, write_data_d;

   wb_fifo #(
      .DW    (XLEN),
      .AW    (REG_AW),
      .DEPTH (LSU_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_rd   (i_lsu_rd),
      .push_data (i_lsu_data),
      .pop       (pop_s),
      .count     (count_s),
      .ent_valid (ent_valid_s),
      .ent_rd    (ent_rd_s),
      .ent_data  (ent_data_s)
   );

   // Ready comes only from the registered occupancy, and is held low in reset.
   assign o_lsu_ready = (rst != RST_ENABLE) && (count_s < FULL_CNT);

   // Source selection, FIFO control, starvation age and next output register.
   always_comb begin
      alu_eff_s    = i_alu_valid && (i_alu_rd != {REG_AW{1'b0}});
      lsu_hs_s     = i_lsu_valid && o_lsu_ready;
      lsu_keep_s   = lsu_hs_s && (i_lsu_rd != {REG_AW{1'b0}});
      fifo_empty_s = (count_s == {CW{1'b0}});

      if (alu_eff_s) begin
         sel_s = SEL_ALU;
      end else if (!fifo_empty_s) begin
         sel_s = SEL_FIFO;
      end else if (lsu_keep_s) begin
         sel_s = SEL_BYPASS;
      end else begin
         sel_s = SEL_NONE;
      end

      pop_s  = (sel_s == SEL_FIFO);
      push_s = lsu_keep_s && (sel_s != SEL_BYPASS);

      case ({push_s, pop_s})
         2'b10:   count_next_s = count_s + 1'b1;
         2'b01:   count_next_s = count_s - 1'b1;
         default: count_next_s = count_s;
      endcase

      // The head ages while it sits unpopped; a pop hands a fresh head age 0.
      if (pop_s) begin
         age_d = {AGW{1'b0}};
      end else if (!fifo_empty_s) begin
         age_d = (age_q == AGE_MAX) ? age_q : age_q + 1'b1;
      end else begin
         age_d = {AGW{1'b0}};
      end

      alu_stall_d = (age_d >= AGE_MAX) || (count_next_s == FULL_CNT);

      write_flag_d = 1'b0;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      case (sel_s)
         SEL_ALU: begin
            write_flag_d = WRITE_ENABLE;
            write_addr_d = i_alu_rd;
            write_data_d = i_alu_data;
         end
         SEL_FIFO: begin
            write_flag_d = WRITE_ENABLE;
            write_addr_d = ent_rd_s[0 +: REG_AW];
            write_data_d = ent_data_s[0 +: XLEN];
         end
         SEL_BYPASS: begin
            write_flag_d = WRITE_ENABLE;
            write_addr_d = i_lsu_rd;
            write_data_d = i_lsu_data;
         end
         default: begin
            write_flag_d = 1'b0;
         end
      endcase
   end

   // Output register, stall flag and age counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         age_q        <= {AGW{1'b0}};
         alu_stall_q  <= 1'b0;
         write_flag_q <= 1'b0;
         write_addr_q <= {REG_AW{1'b0}};
         write_data_q <= {XLEN{1'b0}};
      end else begin
         age_q        <= age_d;
         alu_stall_q  <= alu_stall_d;
         write_flag_q <= write_flag_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
      end
   end

   // Pending-write mask: live FIFO entries plus the write landing this cycle.
   always_comb begin
      o_pend_mask = ZERO_32BIT;
      for (int k = 0; k < LSU_DEPTH; k++) begin
         if (ent_valid_s[k]) begin
            o_pend_mask[ent_rd_s[k*REG_AW +: REG_AW]] = 1'b1;
         end else begin
            o_pend_mask = o_pend_mask;
         end
      end
      if (write_flag_q) begin
         o_pend_mask[write_addr_q] = 1'b1;
      end else begin
         o_pend_mask = o_pend_mask;
      end
      o_pend_mask[0] = 1'b0;
   end

   // Forwarding: output register first, then FIFO entries oldest-first.
   always_comb begin
      o_fwd_hit  = 1'b0;
      o_fwd_data = {XLEN{1'b0}};
      if (i_fwd_addr == {REG_AW{1'b0}}) begin
         o_fwd_hit  = 1'b0;
         o_fwd_data = {XLEN{1'b0}};
      end else if (write_flag_q && (write_addr_q == i_fwd_addr)) begin
         o_fwd_hit  = 1'b1;
         o_fwd_data = write_data_q;
      end else begin
         for (int k = 0; k < LSU_DEPTH; k++) begin
            if (!o_fwd_hit && ent_valid_s[k] &&
                (ent_rd_s[k*REG_AW +: REG_AW] == i_fwd_addr)) begin
               o_fwd_hit  = 1'b1;
               o_fwd_data = ent_data_s[k*XLEN +: XLEN];
            end else begin
               o_fwd_hit = o_fwd_hit;
            end
         end
      end
   end

   assign o_alu_stall  = alu_stall_q;
   assign o_write_flag = write_flag_q;
   assign o_write_addr = write_addr_q;
   assign o_write_data = write_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter. Expected register-file writes are queued as
// stimulus is issued; a negedge monitor pops and compares every write.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_alu_valid = 1'b0;
   logic [4:0]  i_alu_rd = 5'd0;
   logic [31:0] i_alu_data = 32'h0;
   logic        i_lsu_valid = 1'b0;
   logic        o_lsu_ready;
   logic [4:0]  i_lsu_rd = 5'd0;
   logic [31:0] i_lsu_data = 32'h0;
   logic        o_alu_stall;
   logic        o_write_flag;
   logic [4:0]  o_write_addr;
   logic [31:0] o_write_data;
   logic [31:0] o_pend_mask;
   logic [4:0]  i_fwd_addr = 5'd0;
   logic        o_fwd_hit;
   logic [31:0] o_fwd_data;

   int checks = 0;
   int errors = 0;

   logic [4:0]  exp_rd_q   [$];
   logic [31:0] exp_data_q [$];
   logic [4:0]  mon_rd;
   logic [31:0] mon_data;
   logic [4:0]  alu_next;

   wb_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .i_alu_valid  (i_alu_valid),
      .i_alu_rd     (i_alu_rd),
      .i_alu_data   (i_alu_data),
      .i_lsu_valid  (i_lsu_valid),
      .o_lsu_ready  (o_lsu_ready),
      .i_lsu_rd     (i_lsu_rd),
      .i_lsu_data   (i_lsu_data),
      .o_alu_stall  (o_alu_stall),
      .o_write_flag (o_write_flag),
      .o_write_addr (o_write_addr),
      .o_write_data (o_write_data),
      .o_pend_mask  (o_pend_mask),
      .i_fwd_addr   (i_fwd_addr),
      .o_fwd_hit    (o_fwd_hit),
      .o_fwd_data   (o_fwd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
      exp_rd_q.push_back(rd);
      exp_data_q.push_back(data);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_alu_valid = 1'b0;
      i_alu_rd    = 5'd0;
      i_alu_data  = 32'h0;
      i_lsu_valid = 1'b0;
      i_lsu_rd    = 5'd0;
      i_lsu_data  = 32'h0;
   endtask

   // Drive the next ALU result unless the arbiter is asking for a hold.
   task automatic drive_alu();
      if (!o_alu_stall) begin
         i_alu_valid = 1'b1;
         i_alu_rd    = alu_next;
         i_alu_data  = 32'h1000 + {27'd0, alu_next};
         alu_next    = alu_next + 5'd1;
      end else begin
         i_alu_valid = 1'b0;
      end
   endtask

   // Monitor: every register-file write must match the head of the queue.
   always @(negedge clk) begin
      if (!rst && o_write_flag) begin
         checks++;
         if (exp_rd_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write",
                     o_write_addr, o_write_data);
         end else begin
            mon_rd   = exp_rd_q.pop_front();
            mon_data = exp_data_q.pop_front();
            if (o_write_addr !== mon_rd || o_write_data !== mon_data) begin
               errors++;
               $display("FAIL write: got rd=%0d data=%h expected rd=%0d data=%h",
                        o_write_addr, o_write_data, mon_rd, mon_data);
            end
         end
      end
      if (!rst && i_alu_valid && o_alu_stall) begin
         errors++;
         $display("FAIL alu_protocol: alu_valid=1 while alu_stall=1");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #2;
      check("rst_write_flag", {31'd0, o_write_flag}, 32'd0);
      check("rst_alu_stall", {31'd0, o_alu_stall}, 32'd0);
      check("rst_pend_mask", o_pend_mask, 32'd0);
      check("rst_lsu_ready", {31'd0, o_lsu_ready}, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_lsu_ready", {31'd0, o_lsu_ready}, 32'd1);

      // 1: single ALU write, latency one, pend bit for one cycle
      i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'h1234;
      expect_write(5'd5, 32'h1234);
      tick();
      idle_inputs();
      i_fwd_addr = 5'd5;
      #1;
      check("t1_pend", o_pend_mask, 32'h0000_0020);
      check("t1_fwd_hit", {31'd0, o_fwd_hit}, 32'd1);
      check("t1_fwd_data", o_fwd_data, 32'h1234);
      i_fwd_addr = 5'd6;
      #1;
      check("t1_fwd_miss_data", o_fwd_data, 32'd0);
      tick();
      check("t1_pend_clear", o_pend_mask, 32'd0);

      // 2: LSU bypass when FIFO empty and no ALU
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd7; i_lsu_data = 32'hAA;
      expect_write(5'd7, 32'hAA);
      tick();
      idle_inputs();
      #1;
      check("t2_lsu_ready", {31'd0, o_lsu_ready}, 32'd1);
      check("t2_pend", o_pend_mask, 32'h0000_0080);
      tick();

      // 3: ALU busy, two LSU results fill the FIFO, stall lets them drain
      alu_next = 5'd16;
      expect_write(5'd16, 32'h1010);
      expect_write(5'd17, 32'h1011);
      expect_write(5'd2,  32'hB0);
      expect_write(5'd18, 32'h1012);
      expect_write(5'd19, 32'h1013);
      expect_write(5'd20, 32'h1014);
      expect_write(5'd21, 32'h1015);
      expect_write(5'd3,  32'hB1);
      for (int i = 0; i < 8; i++) begin
         drive_alu();
         i_lsu_valid = (i < 2);
         i_lsu_rd    = (i == 0) ? 5'd2 : 5'd3;
         i_lsu_data  = (i == 0) ? 32'hB0 : 32'hB1;
         tick();
         check($sformatf("t3_stall_%0d", i), {31'd0, o_alu_stall},
               {31'd0, (i == 1 || i == 6)});
         check($sformatf("t3_ready_%0d", i), {31'd0, o_lsu_ready},
               {31'd0, (i != 1)});
         if (i == 1) begin
            i_fwd_addr = 5'd3;
            #1;
            check("t3_pend_full", o_pend_mask, 32'h0002_000C);
            check("t3_fwd_tail", o_fwd_data, 32'hB1);
         end
      end
      idle_inputs();
      tick();
      check("t3_drained", exp_rd_q.size(), 32'd0);

      // 4: starvation guard with one aging entry
      alu_next = 5'd22;
      expect_write(5'd22, 32'h1016);
      expect_write(5'd23, 32'h1017);
      expect_write(5'd24, 32'h1018);
      expect_write(5'd25, 32'h1019);
      expect_write(5'd26, 32'h101A);
      expect_write(5'd9,  32'h99);
      for (int i = 0; i < 6; i++) begin
         drive_alu();
         i_lsu_valid = (i == 0);
         i_lsu_rd    = 5'd9;
         i_lsu_data  = 32'h99;
         tick();
         check($sformatf("t4_stall_%0d", i), {31'd0, o_alu_stall}, {31'd0, (i == 4)});
      end
      idle_inputs();
      tick();
      check("t4_drained", exp_rd_q.size(), 32'd0);

      // 5: rd=0 filtering on both sources
      i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'hDEAD;
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd4; i_lsu_data = 32'h44;
      expect_write(5'd4, 32'h44);
      tick();
      idle_inputs();
      i_fwd_addr = 5'd4;
      #1;
      check("t5_fwd_rd4", o_fwd_data, 32'h44);
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd0; i_lsu_data = 32'h55;
      check("t5_ready_rd0", {31'd0, o_lsu_ready}, 32'd1);
      tick();
      idle_inputs();
      i_fwd_addr = 5'd0;
      #1;
      check("t5_no_write_rd0", {31'd0, o_write_flag}, 32'd0);
      check("t5_ready_after", {31'd0, o_lsu_ready}, 32'd1);
      check("t5_pend_empty", o_pend_mask, 32'd0);
      check("t5_fwd0_hit", {31'd0, o_fwd_hit}, 32'd0);
      check("t5_fwd0_data", o_fwd_data, 32'd0);
      tick();

      // 6: asynchronous reset with a full FIFO and a write in flight
      i_alu_valid = 1'b1; i_alu_rd = 5'd12; i_alu_data = 32'hC;
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd13; i_lsu_data = 32'hD;
      expect_write(5'd12, 32'hC);
      tick();
      i_alu_rd = 5'd14; i_alu_data = 32'hE;
      i_lsu_rd = 5'd15; i_lsu_data = 32'hF;
      tick();
      idle_inputs();
      check("t6_pre_flag", {31'd0, o_write_flag}, 32'd1);
      check("t6_pre_addr", {27'd0, o_write_addr}, 32'd14);
      check("t6_pre_pend", o_pend_mask, 32'h0000_E000);
      check("t6_pre_stall", {31'd0, o_alu_stall}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("t6_rst_flag", {31'd0, o_write_flag}, 32'd0);
      check("t6_rst_addr", {27'd0, o_write_addr}, 32'd0);
      check("t6_rst_data", o_write_data, 32'd0);
      check("t6_rst_stall", {31'd0, o_alu_stall}, 32'd0);
      check("t6_rst_pend", o_pend_mask, 32'd0);
      check("t6_rst_ready", {31'd0, o_lsu_ready}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      i_fwd_addr = 5'd13;
      tick();
      tick();
      tick();
      check("t6_post_flag", {31'd0, o_write_flag}, 32'd0);
      check("t6_post_pend", o_pend_mask, 32'd0);
      check("t6_post_ready", {31'd0, o_lsu_ready}, 32'd1);
      check("t6_post_fwd", {31'd0, o_fwd_hit}, 32'd0);
      check("final_queue_empty", exp_rd_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
